// File: rtl/truth_pkg.sv
// truth_pkg: shared state type, widths and default truth table for the response checker
package truth_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;
    localparam logic [7:0] DEFAULT_TRUTH = 8'b0000_1011;
    localparam int IDX_W = 3;
    localparam int ERR_W = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear; sat_o flags all-ones so callers can stop incrementing
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);
    logic [W-1:0] count_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) count_q <= '0;
        else if (inc_i) count_q <= count_q + 1'b1;
    end
    assign count_o = count_q;
    assign sat_o = &count_q;
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: checks streamed {a,b,c,f} samples against a truth table, tracking coverage,
// mismatches and an idle timeout
module truth_table_checker
    import truth_pkg::*;
#(
    parameter logic [7:0] TRUTH = DEFAULT_TRUTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       covered,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx
);
    state_e state_q, state_d;
    logic in_ready_q, busy_q, done_q, timeout_q, first_err_valid_q;
    logic [7:0] covered_q, covered_d, idle_cnt;
    logic [IDX_W-1:0] first_err_idx_q, idx;
    logic [ERR_W-1:0] err_cnt;
    logic idle_sat, err_sat, accept, mismatch, start_run, timeout_hit;

    assign idx = {a, b, c};
    assign accept = in_valid && in_ready_q;
    assign mismatch = f != TRUTH[idx];
    assign start_run = start && state_q != COLLECT;
    assign covered_d = covered_q | (8'd1 << idx);
    // an accept on the would-be timeout cycle takes priority and restarts the idle count
    assign timeout_hit = state_q == COLLECT && !accept && idle_cnt == 8'(TIMEOUT);

    always_comb state_d = start_run ? COLLECT :
                          ((accept && covered_d == 8'hFF) || timeout_hit) ? DONE : state_q;

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk(clk), .rst(rst), .clr_i(start_run),
        .inc_i(accept && mismatch && !err_sat),
        .count_o(err_cnt), .sat_o(err_sat)
    );

    sat_counter #(.W(8)) u_idle_cnt (
        .clk(clk), .rst(rst), .clr_i(start_run || accept),
        .inc_i(state_q == COLLECT && !accept && !idle_sat),
        .count_o(idle_cnt), .sat_o(idle_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            in_ready_q        <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            timeout_q         <= 1'b0;
            covered_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d == COLLECT;
            busy_q     <= state_d == COLLECT;
            done_q     <= state_d == DONE;
            if (start_run) begin
                timeout_q         <= 1'b0;
                covered_q         <= '0;
                first_err_valid_q <= 1'b0;
                first_err_idx_q   <= '0;
            end else if (accept) begin
                covered_q <= covered_d;
                if (mismatch && !first_err_valid_q) begin
                    first_err_valid_q <= 1'b1;
                    first_err_idx_q   <= idx;
                end
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign busy = busy_q;
    assign done = done_q;
    assign timeout = timeout_q;
    assign covered = covered_q;
    assign err_count = err_cnt;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx = first_err_idx_q;
    assign pass = done_q && covered_q == 8'hFF && err_cnt == '0 && !timeout_q;
endmodule
